// File: rtl/undertale_pkg.sv
// Shared constants, slot payload type and geometry helper for the flower battle.
package undertale_pkg;

    localparam logic [3:0]  STATUS_FLOWER = 4'd5;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned BOX_LEFT     = 32;
    localparam int unsigned BOX_RIGHT    = 608;
    localparam int unsigned BOX_BOTTOM   = 450;
    localparam int unsigned NUM_PATTERNS = 5;

    // Horizontal drift per frame, cycled through on each spawn attempt.
    localparam logic signed [2:0] DX_PATTERN [NUM_PATTERNS] =
        '{-3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2};

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic signed [2:0]  dx;
    } bullet_slot_t;

    // Half-open interval overlap [a,a+a_len) vs [b,b+b_len), widened so the ends never wrap.
    function automatic logic span_overlap(input logic [COORD_W-1:0] a, input logic [COORD_W:0] a_len,
                                          input logic [COORD_W-1:0] b, input logic [COORD_W:0] b_len);
        return ({1'b0, a} < ({1'b0, b} + b_len)) && ({1'b0, b} < ({1'b0, a} + a_len));
    endfunction

endpackage

// File: rtl/flower_bullet_engine_render.sv
// Per-pixel bullet lookup for the color mapper.
//   en               : rendering allowed (engine running, not in reset)
//   slot_valid/x/y   : registered slot state
//   draw_x/draw_y    : current pixel
//   is_bullet_c      : pixel inside any active bullet
//   bullet_address_c : sprite ROM index from the lowest-index covering slot
module flower_bullet_engine_render
    import undertale_pkg::*;
#(
    parameter int unsigned NUM_BULLETS = 8,
    parameter int unsigned BULLET_SIZE = 8
) (
    input  logic                                  en,
    input  logic [NUM_BULLETS-1:0]                slot_valid,
    input  logic [NUM_BULLETS-1:0][COORD_W-1:0]   slot_x,
    input  logic [NUM_BULLETS-1:0][COORD_W-1:0]   slot_y,
    input  logic [COORD_W-1:0]                    draw_x,
    input  logic [COORD_W-1:0]                    draw_y,
    output logic                                  is_bullet_c,
    output logic [5:0]                            bullet_address_c
);

    // Scan from the top slot down so the lowest-index covering slot is written last.
    always_comb begin : lookup
        logic [COORD_W-1:0] off_x;
        logic [COORD_W-1:0] off_y;
        logic [COORD_W-1:0] row_base;
        is_bullet_c      = 1'b0;
        bullet_address_c = '0;
        off_x            = '0;
        off_y            = '0;
        row_base         = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (en && slot_valid[i]
                && span_overlap(draw_x, 11'd1, slot_x[i], 11'(BULLET_SIZE))
                && span_overlap(draw_y, 11'd1, slot_y[i], 11'(BULLET_SIZE))) begin
                off_x            = draw_x - slot_x[i];
                off_y            = draw_y - slot_y[i];
                row_base         = off_y * 10'(BULLET_SIZE);
                is_bullet_c      = 1'b1;
                bullet_address_c = 6'(row_base + off_x);
            end
        end
    end

endmodule

// File: rtl/flower_bullet_engine.sv
// Friendliness-pellet engine for the flower battle (status 5).
//   frame_clk, Reset       : frame clock, synchronous active-high reset
//   status, start_bullet   : run gate and spawn enable from the sequencer
//   heart_x, heart_y       : heart top-left for collision
//   DrawX, DrawY           : current pixel for rendering
//   is_bullet, bullet_address : combinational pixel lookup
//   hit                    : one-frame pulse after any collision
//   active_count           : number of live slots
module flower_bullet_engine
    import undertale_pkg::*;
#(
    parameter int unsigned NUM_BULLETS  = 8,
    parameter int unsigned SPAWN_PERIOD = 30,
    parameter int unsigned BULLET_SIZE  = 8,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned ORIGIN_X     = 316,
    parameter int unsigned ORIGIN_Y     = 210,
    parameter int unsigned HEART_SIZE   = 16
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [3:0] status,
    input  logic       start_bullet,
    input  logic [9:0] heart_x,
    input  logic [9:0] heart_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_bullet,
    output logic [5:0] bullet_address,
    output logic       hit,
    output logic [3:0] active_count
);

    localparam int unsigned CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    bullet_slot_t [NUM_BULLETS-1:0] slots_q, slots_d;
    logic [CNT_W-1:0]               spawn_cnt_q, spawn_cnt_d;
    logic [2:0]                     pattern_q, pattern_d;
    logic                           hit_q, hit_d;
    logic [3:0]                     active_count_q, active_count_d;

    // Collide / move / retire every slot, then spawn into a slot free at frame start.
    always_comb begin : next_state
        logic [COORD_W-1:0] mx;
        logic [COORD_W-1:0] my;
        logic               spawn;
        logic               placed;
        slots_d        = slots_q;
        spawn_cnt_d    = spawn_cnt_q;
        pattern_d      = pattern_q;
        hit_d          = 1'b0;
        active_count_d = '0;
        mx             = '0;
        my             = '0;
        spawn          = 1'b0;
        placed         = 1'b0;

        if (status != STATUS_FLOWER) begin
            slots_d     = '0;
            spawn_cnt_d = '0;
            pattern_d   = '0;
        end else begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (slots_q[i].valid) begin
                    if (span_overlap(slots_q[i].x, 11'(BULLET_SIZE), heart_x, 11'(HEART_SIZE))
                        && span_overlap(slots_q[i].y, 11'(BULLET_SIZE), heart_y, 11'(HEART_SIZE))) begin
                        slots_d[i].valid = 1'b0;
                        hit_d            = 1'b1;
                    end else begin
                        // dx is sign-extended by the width cast before the 10-bit add.
                        mx = slots_q[i].x + 10'(slots_q[i].dx);
                        my = slots_q[i].y + 10'(SPEED);
                        slots_d[i].x = mx;
                        slots_d[i].y = my;
                        if ((my >= 10'(BOX_BOTTOM)) || (mx < 10'(BOX_LEFT))
                            || (({1'b0, mx} + 11'(BULLET_SIZE)) > 11'(BOX_RIGHT))) begin
                            slots_d[i].valid = 1'b0;
                        end
                    end
                end
            end

            if (start_bullet) begin
                spawn       = (spawn_cnt_q == '0);
                spawn_cnt_d = (spawn_cnt_q == CNT_W'(SPAWN_PERIOD - 1)) ? '0 : spawn_cnt_q + 1'b1;
            end else begin
                spawn_cnt_d = '0;
            end

            if (spawn) begin
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (!placed && !slots_q[i].valid) begin
                        placed           = 1'b1;
                        slots_d[i].valid = 1'b1;
                        slots_d[i].x     = 10'(ORIGIN_X);
                        slots_d[i].y     = 10'(ORIGIN_Y);
                        slots_d[i].dx    = DX_PATTERN[pattern_q];
                    end
                end
                // Pattern advances even when every slot is busy.
                pattern_d = (pattern_q == 3'(NUM_PATTERNS - 1)) ? 3'd0 : pattern_q + 3'd1;
            end
        end

        for (int i = 0; i < NUM_BULLETS; i++) begin
            active_count_d = active_count_d + 4'(slots_d[i].valid);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            slots_q        <= '0;
            spawn_cnt_q    <= '0;
            pattern_q      <= '0;
            hit_q          <= 1'b0;
            active_count_q <= '0;
        end else begin
            slots_q        <= slots_d;
            spawn_cnt_q    <= spawn_cnt_d;
            pattern_q      <= pattern_d;
            hit_q          <= hit_d;
            active_count_q <= active_count_d;
        end
    end

    logic [NUM_BULLETS-1:0]              slot_valid;
    logic [NUM_BULLETS-1:0][COORD_W-1:0] slot_x;
    logic [NUM_BULLETS-1:0][COORD_W-1:0] slot_y;

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot_view
        assign slot_valid[g] = slots_q[g].valid;
        assign slot_x[g]     = slots_q[g].x;
        assign slot_y[g]     = slots_q[g].y;
    end

    flower_bullet_engine_render #(
        .NUM_BULLETS (NUM_BULLETS),
        .BULLET_SIZE (BULLET_SIZE)
    ) u_render (
        .en               (!Reset && (status == STATUS_FLOWER)),
        .slot_valid       (slot_valid),
        .slot_x           (slot_x),
        .slot_y           (slot_y),
        .draw_x           (DrawX),
        .draw_y           (DrawY),
        .is_bullet_c      (is_bullet),
        .bullet_address_c (bullet_address)
    );

    assign hit          = hit_q;
    assign active_count = active_count_q;

endmodule

// File: tb/tb_flower_bullet_engine.sv
// Bench for flower_bullet_engine: default build (a) and a SPAWN_PERIOD=1 build (b)
// share inputs and are checked against a plain-arithmetic slot model.
module tb_flower_bullet_engine;

    logic       frame_clk;
    logic       Reset;
    logic [3:0] status;
    logic       start_bullet;
    logic [9:0] heart_x, heart_y;
    logic [9:0] DrawX, DrawY;

    logic       is_bullet_a, is_bullet_b;
    logic [5:0] addr_a, addr_b;
    logic       hit_a, hit_b;
    logic [3:0] active_a, active_b;

    int errors = 0;
    int checks = 0;

    // Model state per build: index 0 = default, 1 = fast spawn.
    int m_valid [2][8];
    int m_x     [2][8];
    int m_y     [2][8];
    int m_dx    [2][8];
    int m_cnt   [2];
    int m_pat   [2];
    int m_hit   [2];
    int m_act   [2];
    int period  [2] = '{30, 1};
    int dx_tab  [5] = '{-2, -1, 0, 1, 2};

    flower_bullet_engine dut_a (
        .frame_clk(frame_clk), .Reset(Reset), .status(status), .start_bullet(start_bullet),
        .heart_x(heart_x), .heart_y(heart_y), .DrawX(DrawX), .DrawY(DrawY),
        .is_bullet(is_bullet_a), .bullet_address(addr_a), .hit(hit_a), .active_count(active_a)
    );

    flower_bullet_engine #(.SPAWN_PERIOD(1)) dut_b (
        .frame_clk(frame_clk), .Reset(Reset), .status(status), .start_bullet(start_bullet),
        .heart_x(heart_x), .heart_y(heart_y), .DrawX(DrawX), .DrawY(DrawY),
        .is_bullet(is_bullet_b), .bullet_address(addr_b), .hit(hit_b), .active_count(active_b)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame of the game rules applied to build k.
    task automatic model_step(input int k);
        int was_valid [8];
        int hx, hy, nx, ny;
        bit hit_now, spawn;
        hx = int'(heart_x);
        hy = int'(heart_y);
        if (Reset || status != 4'd5) begin
            for (int i = 0; i < 8; i++) m_valid[k][i] = 0;
            m_cnt[k] = 0; m_pat[k] = 0; m_hit[k] = 0; m_act[k] = 0;
            return;
        end
        hit_now = 0;
        for (int i = 0; i < 8; i++) begin
            was_valid[i] = m_valid[k][i];
            if (m_valid[k][i] != 0) begin
                if (m_x[k][i] < hx + 16 && hx < m_x[k][i] + 8 &&
                    m_y[k][i] < hy + 16 && hy < m_y[k][i] + 8) begin
                    m_valid[k][i] = 0;
                    hit_now = 1;
                end else begin
                    nx = (m_x[k][i] + m_dx[k][i] + 1024) % 1024;
                    ny = (m_y[k][i] + 2) % 1024;
                    if (ny >= 450 || nx < 32 || nx + 8 > 608) m_valid[k][i] = 0;
                    m_x[k][i] = nx;
                    m_y[k][i] = ny;
                end
            end
        end
        spawn = 0;
        if (start_bullet) begin
            spawn = (m_cnt[k] == 0);
            m_cnt[k] = (m_cnt[k] + 1) % period[k];
        end else begin
            m_cnt[k] = 0;
        end
        if (spawn) begin
            for (int i = 0; i < 8; i++) begin
                if (was_valid[i] == 0) begin
                    m_valid[k][i] = 1;
                    m_x[k][i] = 316;
                    m_y[k][i] = 210;
                    m_dx[k][i] = dx_tab[m_pat[k]];
                    break;
                end
            end
            m_pat[k] = (m_pat[k] + 1) % 5;
        end
        m_hit[k] = hit_now;
        m_act[k] = 0;
        for (int i = 0; i < 8; i++) m_act[k] += m_valid[k][i];
    endtask

    task automatic m_render(input int k, input int px, input int py, output int eb, output int ea);
        eb = 0;
        ea = 0;
        if (Reset || status != 4'd5) return;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[k][i] != 0 && px >= m_x[k][i] && px < m_x[k][i] + 8 &&
                py >= m_y[k][i] && py < m_y[k][i] + 8) begin
                eb = 1;
                ea = ((py - m_y[k][i]) * 8 + (px - m_x[k][i])) % 64;
                return;
            end
        end
    endtask

    task automatic probe(input int px, input int py);
        int eb, ea;
        DrawX = 10'(px);
        DrawY = 10'(py);
        #1;
        m_render(0, px, py, eb, ea);
        check("is_bullet_a", 32'(is_bullet_a), eb);
        check("addr_a", 32'(addr_a), ea);
        m_render(1, px, py, eb, ea);
        check("is_bullet_b", 32'(is_bullet_b), eb);
        check("addr_b", 32'(addr_b), ea);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        model_step(0);
        model_step(1);
        #1;
        check("hit_a", 32'(hit_a), m_hit[0]);
        check("active_a", 32'(active_a), m_act[0]);
        check("hit_b", 32'(hit_b), m_hit[1]);
        check("active_b", 32'(active_b), m_act[1]);
    endtask

    // Frame plus a probe inside a random live bullet and one random pixel.
    task automatic frame();
        int k, s;
        int cand[$];
        tick();
        k = int'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) if (m_valid[k][i] != 0) cand.push_back(i);
        if (cand.size() > 0) begin
            s = cand[$urandom_range(0, cand.size() - 1)];
            probe(m_x[k][s] + int'($urandom_range(0, 7)), m_y[k][s] + int'($urandom_range(0, 7)));
        end else begin
            probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        end
        probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    endtask

    initial begin
        Reset = 1'b1; status = 4'd5; start_bullet = 1'b1;
        heart_x = '0; heart_y = '0; DrawX = '0; DrawY = '0;

        // Reset held two frames.
        frame();
        frame();
        check("reset_active_a", 32'(active_a), 0);
        check("reset_hit_a", 32'(hit_a), 0);

        // Spawn stream with heart out of the way.
        Reset = 1'b0;
        frame();
        check("first_spawn_count", 32'(active_a), 1);
        probe(316, 210);
        check("first_spawn_pix", 32'(is_bullet_a), 1);
        check("first_spawn_addr", 32'(addr_a), 0);
        for (int e = 1; e <= 60; e++) frame();
        check("three_spawns", 32'(active_a), 3);
        check("fast_full", 32'(active_b), 8);
        probe(196, 330);
        check("slot0_at_330", 32'(is_bullet_a), 1);
        check("slot0_addr0", 32'(addr_a), 0);
        probe(203, 337);
        check("slot0_addr63", 32'(addr_a), 63);

        // Leaving the battle: render gated before the edge, slots cleared on it.
        status = 4'd0;
        probe(196, 330);
        check("status_gate", 32'(is_bullet_a), 0);
        frame();
        check("cleared_a", 32'(active_a), 0);
        check("cleared_b", 32'(active_b), 0);
        check("clear_no_hit", 32'(hit_b), 0);
        frame();

        // Single bullet walks into the heart.
        status = 4'd5; Reset = 1'b1;
        heart_x = 10'd300; heart_y = 10'd226;
        frame();
        Reset = 1'b0;
        frame();
        start_bullet = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            frame();
            check("collide_hit", 32'(hit_a), (e == 6) ? 1 : 0);
            if (e == 6) check("collide_freed", 32'(active_a), 0);
        end

        // dx=0 bullet leaves through the bottom without a hit.
        Reset = 1'b1; heart_x = '0; heart_y = '0; start_bullet = 1'b1;
        frame();
        Reset = 1'b0;
        for (int e = 0; e <= 185; e++) begin
            if (e == 61) start_bullet = 1'b0;
            frame();
            if (e == 179) begin
                probe(316, 448);
                check("bottom_last", 32'(is_bullet_a), 1);
            end
            if (e == 180) begin
                probe(316, 448);
                check("bottom_gone", 32'(is_bullet_a), 0);
                check("bottom_no_hit", 32'(hit_a), 0);
            end
        end

        // Random play around the spawn stream.
        for (int e = 0; e < 300; e++) begin
            start_bullet = ($urandom_range(0, 9) != 0);
            status = ($urandom_range(0, 59) == 0) ? 4'd0 : 4'd5;
            if ($urandom_range(0, 3) == 0) begin
                heart_x = 10'($urandom_range(250, 380));
                heart_y = 10'($urandom_range(200, 460));
            end
            frame();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
